// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (0 = EX stage,
//   1 = branch/address-compare helper). One operation is in flight at a
//   time: IDLE grants and latches operands, EXEC lets the ALU settle on
//   the registered operands and captures result/flags, RESP holds the
//   response until the consumer takes it.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   reqN_valid/a/b/op        requester N operation (N = 0, 1)
//   reqN_ready               requester N accepted this cycle (IDLE only)
//   alu_a/alu_b/alu_ctrl     registered operands/control to the shared ALU
//   alu_result/alu_flags     ALU outputs, flags = {N, Z, C, V}
//   resp_valid/id/result/flags, resp_ready   response handshake
//   busy                     FSM not in IDLE
module alu_share_arbiter #(
    parameter bit          RR_EN  = 1'b1,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              req1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic [3:0]        resp_flags,
    input  logic              resp_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nx;
    logic              rr_ptr;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic [2:0]        opnd_ctrl;
    logic              win_id;
    logic              gnt_vld, gnt_id, accept;

    // Grant selection; only meaningful while in IDLE.
    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (RR_EN) begin
            if (req0_valid && req1_valid) gnt_id = rr_ptr;
            else                          gnt_id = req1_valid;
        end else begin
            gnt_id = ~req0_valid;
        end
    end

    // Ready is held low while rst is asserted so no handshake can slip in
    // during the reset cycle itself.
    always_comb begin
        req0_ready = (state == IDLE) && !rst && gnt_vld && !gnt_id;
        req1_ready = (state == IDLE) && !rst && gnt_vld &&  gnt_id;
        accept     = req0_ready | req1_ready;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: state_nx = RESP;
            RESP: if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            opnd_a      <= '0;
            opnd_b      <= '0;
            opnd_ctrl   <= '0;
            win_id      <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opnd_a    <= gnt_id ? req1_a  : req0_a;
                opnd_b    <= gnt_id ? req1_b  : req0_b;
                opnd_ctrl <= gnt_id ? req1_op : req0_op;
                win_id    <= gnt_id;
                if (RR_EN) rr_ptr <= ~gnt_id;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_flags  <= alu_flags;
                resp_id     <= win_id;
            end
        end
    end

    always_comb begin
        alu_a      = opnd_a;
        alu_b      = opnd_b;
        alu_ctrl   = opnd_ctrl;
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU instance between two requesters: requester 0 is the EX stage and requester 1 is the branch/address-compare helper.
- Accepts one operation at a time over a valid/ready handshake and arbitrates between the requesters (round-robin, or fixed priority).
- Drives the ALU operand and control inputs from registered state, captures the result and flags, and returns them to the winning requester over a response handshake.
- Only one operation is outstanding at a time.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 always winning.
- DATA_W, 32, operand and result width; must match the ALU (32).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a  in  DATA_W  requester 0 operand A.
- req0_b  in  DATA_W  requester 0 operand B.
- req0_op  in  3  requester 0 ALU control code.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_op, req1_ready: same as requester 0, for requester 1.
- alu_a  out  DATA_W  operand A to the shared ALU.
- alu_b  out  DATA_W  operand B to the shared ALU.
- alu_ctrl  out  3  control code to the shared ALU.
- alu_result  in  DATA_W  ALU result.
- alu_flags  in  4  {Negative, zero, Carry, OverFlow} from the ALU.
- resp_valid  out  1  response available.
- resp_id  out  1  requester the response belongs to.
- resp_result  out  DATA_W  captured result.
- resp_flags  out  4  captured flags, same order as alu_flags.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  FSM not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - State = IDLE; rr_ptr = 0 (requester 0 preferred).
  - req0_ready = req1_ready = 0; resp_valid = 0; busy = 0.
  - resp_id = 0; resp_result = 0; resp_flags = 0.
  - alu_a = alu_b = 0; alu_ctrl = 3'b000.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from reqN_valid and rr_ptr.
  - Only the granted requester sees readyN = 1, in the same cycle. ready is asserted only in IDLE.
  - On a handshake, register a/b/op into the operand register, record the winner id, and go to EXEC.
  - With no valid request, stay in IDLE.
- Arbitration:
  - RR_EN = 1: if both requesters are valid, the requester indicated by rr_ptr wins; rr_ptr then flips to the other requester. If only one is valid it wins, and rr_ptr is set to the other requester.
  - RR_EN = 0: requester 0 always wins when valid; rr_ptr is unused.
- alu_a/alu_b/alu_ctrl are driven only from the operand register. They never come combinationally from req ports. They hold their last value outside EXEC.
- EXEC (exactly 1 cycle):
  - At the end of the cycle, capture alu_result and alu_flags into the resp registers.
  - resp_id = the recorded winner id.
  - Next state is RESP.
- RESP:
  - resp_valid = 1; resp_id, resp_result and resp_flags are held stable until the handshake.
  - On resp_valid & resp_ready: go to IDLE and drop resp_valid in the next cycle.
  - No new request is accepted in the cycle the response handshake occurs.
- Latency: request handshake at cycle N, resp_valid = 1 at cycle N+2. Minimum issue interval is 3 cycles.
- Opcodes (000 add, 001 sub, 010 and, 011 or, 101 slt) pass through unchecked. Codes 100, 110 and 111 are issued normally; the ALU returns 0 with zero = 1, and that is forwarded as-is.
- Requests are not required to stay stable before grant. Operands are sampled only at the handshake cycle.
- A requester that deasserts valid before being granted loses nothing; there is no state for it.
- busy = (state != IDLE).
- Reset asserted in any state, including mid-EXEC or RESP with resp_ready low:
  - The next cycle is IDLE with all outputs at reset values.
  - The in-flight operation is discarded and no response is produced.
- Simultaneous resp_ready and new reqN_valid in RESP: the response completes; the request waits and can be granted from the following IDLE cycle.

Test Plan:
- Req0 only, a=5, b=7, op=000 → req0_ready=1 at N; alu_a=5, alu_b=7 in EXEC; resp at N+2 with id=0, result=12, flags=0100? No, zero=0, so flags=4'b0000.
- Req1 only, a=3, b=3, op=001 → resp id=1, result=0, zero flag set, flags=4'b0110 (Negative=0, zero=1, Carry=1 from the two's-complement add, OverFlow=0).
- Both valid every cycle, RR_EN=1, resp_ready=1 → grants alternate 0,1,0,1, one every 3 cycles. With RR_EN=0, grants are all 0.
- Req0 a=0x7FFFFFFF, b=1, op=000; resp_ready held low for 5 cycles → resp_valid and result=0x80000000 with Negative=1, OverFlow=1 stay stable; both readys stay 0 throughout.
- rst pulsed during EXEC of a=2, b=9, op=101 → the next cycle is IDLE with resp_valid=0, and the op is never returned. A reissued op returns result=1.
- Req1 op=110, a=0xFFFF, b=0xFFFF → result=0, zero=1, resp_id=1; no error or stall.
